// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci sequence controller: FSM encoding and term-count width.
package fib_seq_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fib_seq_ctrl.sv
// Fibonacci term sequencer: steps an external ripple-carry adder and streams terms out over
// a valid/ready handshake, stopping on the requested count or when the next term overflows.
module fib_seq_ctrl
  import fib_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] fib_out,
  output logic             fib_valid,
  input  logic             fib_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             b_ovf;
  logic [CNT_W-1:0] cnt, tgt;
  logic [CNT_W:0]   cnt_inc;
  logic             accept, hs, last_term;

  assign accept    = start && (state != EMIT);
  assign hs        = (state == EMIT) && fib_ready;
  assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign last_term = (cnt_inc == {1'b0, tgt});

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign fib_valid = (state == EMIT);
  assign fib_out   = fib_valid ? a_q : '0;
  assign busy      = (state == EMIT);
  assign done      = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nx = (n_terms == '0) ? DONE : EMIT;
      end
      EMIT: begin
        // A set b_ovf means the term that would follow this one cannot be represented.
        if (fib_ready && (last_term || b_ovf)) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      b_ovf    <= 1'b0;
      cnt      <= '0;
      tgt      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q      <= '0;
      b_q      <= {{(WIDTH-1){1'b0}}, 1'b1};
      b_ovf    <= 1'b0;
      cnt      <= '0;
      tgt      <= n_terms;
      overflow <= 1'b0;
    end else if (hs) begin
      a_q      <= b_q;
      b_q      <= add_sum;
      b_ovf    <= b_ovf | add_cout;
      cnt      <= cnt_inc[CNT_W-1:0];
      if (!last_term && b_ovf) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a behavioural adder closing the add_a/add_b loop.
module tb_fib_seq_ctrl;
  import fib_seq_ctrl_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] fib_out;
  logic             fib_valid, fib_ready, busy, done, overflow;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] fib_exp [0:7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
  logic [2:0]       rdy_pat = 3'b100;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  fib_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .fib_out(fib_out), .fib_valid(fib_valid), .fib_ready(fib_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    n_terms = n;
    step();
    start   = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_fib_out"}, fib_out, 0);
    chk({tag, "_fib_valid"}, fib_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_add_a"}, add_a, 0);
    chk({tag, "_add_b"}, add_b, 0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; n_terms = '0; fib_ready = 1'b1;
    step(); step();
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    step();
    chk_idle_outputs("idle");

    // Six terms at full throughput
    do_start(4'd6);
    for (int i = 0; i < 6; i++) begin
      chk("n6_valid", fib_valid, 1);
      chk("n6_busy", busy, 1);
      chk("n6_term", fib_out, fib_exp[i]);
      chk("n6_add_a", add_a, fib_exp[i]);
      if (i < 5) chk("n6_add_b", add_b, fib_exp[i+1]);
      step();
    end
    chk("n6_done", done, 1);
    chk("n6_valid_end", fib_valid, 0);
    chk("n6_overflow", overflow, 0);

    // Restart straight from DONE, ask for more terms than fit
    do_start(4'd12);
    for (int i = 0; i < 8; i++) begin
      chk("n12_valid", fib_valid, 1);
      chk("n12_term", fib_out, fib_exp[i]);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("n12_no9th", fib_valid, 0);
      chk("n12_done", done, 1);
      chk("n12_overflow", overflow, 1);
      step();
    end

    // Backpressure: ready pattern 1,0,0 repeating
    do_start(4'd5);
    k = 0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      fib_ready = rdy_pat[2 - (c % 3)];
      chk("bp_valid", fib_valid, 1);
      chk("bp_term", fib_out, fib_exp[k]);
      step();
      if (fib_ready) k++;
    end
    chk("bp_count", k, 5);
    fib_ready = 1'b1;
    chk("bp_done", done, 1);
    chk("bp_overflow", overflow, 0);

    // Zero terms
    do_start(4'd0);
    chk("n0_valid", fib_valid, 0);
    chk("n0_done", done, 1);
    chk("n0_overflow", overflow, 0);
    step();
    chk("n0_valid2", fib_valid, 0);

    // Reset mid-sequence after three terms
    do_start(4'd8);
    for (int i = 0; i < 3; i++) begin
      chk("rst8_term", fib_out, fib_exp[i]);
      step();
    end
    chk("rst8_valid_pre", fib_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", fib_valid, 0);
    chk("post_rst_done", done, 0);
    do_start(4'd3);
    for (int i = 0; i < 3; i++) begin
      chk("n3_valid", fib_valid, 1);
      chk("n3_term", fib_out, fib_exp[i]);
      step();
    end
    chk("n3_done", done, 1);

    // Start pulsed during EMIT is ignored
    do_start(4'd4);
    chk("ign_term0", fib_out, fib_exp[0]);
    step();
    start = 1'b1; n_terms = 4'd9;
    chk("ign_term1", fib_out, fib_exp[1]);
    step();
    start = 1'b0;
    for (int i = 2; i < 4; i++) begin
      chk("ign_valid", fib_valid, 1);
      chk("ign_term", fib_out, fib_exp[i]);
      step();
    end
    chk("ign_done", done, 1);
    chk("ign_overflow", overflow, 0);

    // Start in DONE restarts at term 0
    do_start(4'd2);
    chk("rs_term0", fib_out, fib_exp[0]);
    chk("rs_valid", fib_valid, 1);
    step();
    chk("rs_term1", fib_out, fib_exp[1]);
    step();
    chk("rs_done", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, term/adder operand width.
REQ-002 SHALL have clk  input  1  rising-edge clock, sole clock.
REQ-003 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have start  input  1  one-cycle request to begin a sequence.
REQ-005 SHALL have n_terms  input  4  number of terms to emit, sampled on accepted start.
REQ-006 SHALL have add_a, add_b  output  WIDTH  operands driven to the external ripple-carry adder.
REQ-007 SHALL have add_sum  input  WIDTH, add_cout  input  1  adder result and carry-out.
REQ-008 SHALL have fib_out  output  WIDTH  current term; fib_valid  output  1; fib_ready  input  1.
REQ-009 SHALL have busy  output  1, done  output  1, overflow  output  1.

Function
REQ-010 SHALL implement FSM states IDLE, EMIT, DONE.
REQ-011 SHALL hold registers a_q (current term), b_q (next term), b_ovf (b_q invalid), cnt (terms emitted, 4 bits), tgt (latched n_terms).
REQ-012 SHALL drive add_a=a_q, add_b=b_q combinationally; no adder inside this block.
REQ-013 IDLE/DONE + start: a_q<=0, b_q<=1, b_ovf<=0, cnt<=0, tgt<=n_terms, overflow<=0; next state EMIT, or DONE if n_terms==0.
REQ-014 start SHALL be ignored in EMIT.
REQ-015 In EMIT: fib_valid=1, fib_out=a_q, busy=1; fib_valid=0 and fib_out=0 in all other states.
REQ-016 fib_out, fib_valid SHALL remain stable while fib_valid && !fib_ready (backpressure, no term loss).
REQ-017 On handshake (fib_valid && fib_ready): cnt<=cnt+1, a_q<=b_q, b_q<=add_sum, b_ovf<=b_ovf|add_cout.
REQ-018 On handshake with cnt+1==tgt: next state DONE, overflow stays 0.
REQ-019 On handshake with cnt+1<tgt and b_ovf==1: next state DONE, overflow<=1 (next term unrepresentable, never emitted).
REQ-020 done SHALL be 1 exactly while in DONE; busy SHALL be 1 exactly while in EMIT.
REQ-021 overflow SHALL hold its value in DONE until next accepted start or reset.
REQ-022 Term sequence SHALL be 0,1,1,2,3,5,8,13 for WIDTH=4; maximum valid terms 8.
REQ-023 Throughput SHALL be one term per cycle when fib_ready held high; first fib_valid one cycle after accepted start.
REQ-024 start and handshake cannot coincide (start ignored in EMIT); start in DONE SHALL restart directly.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, a_q=0, b_q=0, b_ovf=0, cnt=0, tgt=0, overflow=0.
REQ-026 Reset outputs: fib_out=0, fib_valid=0, busy=0, done=0, overflow=0, add_a=0, add_b=0.
REQ-027 Reset asserted mid-EMIT SHALL abort the sequence; no further fib_valid until a new start after release.

Structure
REQ-028 Shared package SHALL hold the FSM state enumeration and the constant for the count width (4).
REQ-029 No sub-module SHALL be instantiated; the ripple-carry adder is a sibling instance wired at the generator top level.

Verification
REQ-030 n_terms=6, fib_ready=1 -> fib_out 0,1,1,2,3,5 on consecutive cycles, then done=1, overflow=0.
REQ-031 n_terms=12 -> terms 0,1,1,2,3,5,8,13 emitted, then DONE with overflow=1, no 9th fib_valid.
REQ-032 n_terms=5, fib_ready toggled 1,0,0,1,... -> fib_out frozen during low ready, sequence 0,1,1,2,3 intact.
REQ-033 n_terms=0 -> no fib_valid, done=1 the cycle after start, overflow=0.
REQ-034 rst_n low after third term of n_terms=8 -> all outputs 0 immediately; new start with n_terms=3 gives 0,1,1.
REQ-035 start pulsed during EMIT (n_terms=4) -> ignored, sequence 0,1,1,2 then done; start in DONE restarts at 0.
